ehl_clk_div_ctrl: RTL and testbench
===================================

EHL_CLK_DIV_CTRL -- requirements
Module: ehl_clk_div_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the width of the division ratio.
REQ-002 The module SHALL have parameter TECHNOLOGY, default 0, passed unchanged to child cells (0 = behavioural RTL).
REQ-003 Port clk, input, 1 bit: the single clock; all flops SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 Port i_en, input, 1 bit: run request for the divider.
REQ-006 Port i_div, input, WIDTH bits: new division ratio N.
REQ-007 Port i_div_vld, input, 1 bit: i_div is valid.
REQ-008 Port o_div_rdy, output, 1 bit: the controller can accept a ratio.
REQ-009 Port o_clk_en, output, 1 bit: one-cycle enable pulse, once per divided period.
REQ-010 Port o_clk_div, output, 1 bit: registered divided square wave.
REQ-011 Port o_busy, output, 1 bit: high while the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and STOP.
- IDLE -> RUN when i_en=1.
- RUN -> STOP when i_en=0.
- STOP -> RUN when i_en=1 before the period ends.
- STOP -> IDLE at the period end.
REQ-013 An active ratio register act_div SHALL hold an effective ratio E, where E=1 when N=0 and E=N otherwise.
REQ-014 A period counter cnt SHALL count 0..E-1 in RUN and STOP, wrap to 0 after E-1, and stay at 0 in IDLE.
REQ-015 In RUN or STOP, o_clk_en SHALL be 1 exactly in the cycle where cnt==E-1; it SHALL always be 0 in IDLE.
REQ-016 o_clk_en SHALL be 1 every cycle when E=1, and once every 2^WIDTH-1 cycles when N=2^WIDTH-1.
REQ-017 o_clk_div SHALL be 1 when cnt < E/2 (integer division) and 0 otherwise.
- It SHALL be a flop output with no combinational path from inputs.
- For E=1 it SHALL be constantly 0.
- In IDLE it SHALL be 0.
REQ-018 A ratio transfer SHALL occur on a cycle where i_div_vld=1 and o_div_rdy=1.
REQ-019 A transferred value SHALL be stored in a one-entry pending register, and o_div_rdy SHALL be 0 while that register is occupied.
REQ-020 In IDLE, a pending ratio SHALL be copied to act_div on the next clock, and the pending register SHALL be freed.
REQ-021 In RUN or STOP, a pending ratio SHALL be copied to act_div only at the period end (cnt==E-1).
- From that edge, cnt restarts at 0 with the new E.
- A period SHALL never be truncated or stretched by an update.
REQ-022 If a transfer happens in the same cycle as a period end, that boundary SHALL apply the transferred value directly (forwarding), and the pending register SHALL stay empty.
REQ-023 The first o_clk_en pulse SHALL occur E cycles after the IDLE->RUN edge, using act_div as it is at that edge.
REQ-024 i_div_vld held high with o_div_rdy=0 SHALL NOT change any state; i_div may change while o_div_rdy=0.

Reset
REQ-025 While reset=1, the outputs and state SHALL be:
- FSM in IDLE, cnt=0, act_div=1, pending register empty;
- o_clk_en=0, o_clk_div=0, o_busy=0, o_div_rdy=1.
REQ-026 Reset SHALL take effect immediately and asynchronously, including mid-period or with a pending ratio; the pending ratio SHALL be discarded.
REQ-027 Reset release SHALL be synchronous in effect: the first state change SHALL occur no earlier than the first rising clk edge after reset falls.

Verification
REQ-028 Load N=4 in IDLE, then i_en=1:
- o_clk_en pulses every 4 cycles, the first pulse 4 cycles after RUN entry;
- o_clk_div shows the pattern 1100 repeating.
REQ-029 Run with N=5, then transfer N=3 mid-period:
- the current 5-cycle period completes;
- the next periods are 3 cycles long with o_clk_div pattern 100;
- o_div_rdy is 0 from the transfer until the boundary.
REQ-030 Run with N=0 and with N=1:
- o_clk_en is constantly 1 in RUN;
- o_clk_div stays 0.
REQ-031 Run with N=6 and drop i_en at cnt=2:
- the state goes to STOP;
- pulses continue until cnt=5 with o_clk_en=1;
- then IDLE, o_busy=0, o_clk_div=0.
REQ-032 Transfer a ratio exactly in a cycle with cnt==E-1: the new ratio is active from the next cycle and o_div_rdy never drops.
REQ-033 Assert reset at cnt=3 with a pending ratio; the bench SHALL check:
- the REQ-025 values without a clock edge;
- after release, act_div=1;
- with i_en=1, o_clk_en=1 every cycle.

Source files
------------

// File: rtl/ehl_clk_div_ctrl.sv
// Programmable clock-enable divider with a one-entry ratio staging register.
// Ratio updates take effect only on period boundaries so no period is ever cut short.
module ehl_clk_div_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int          TECHNOLOGY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_vld,
  output logic             o_div_rdy,
  output logic             o_clk_en,
  output logic             o_clk_div,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_div_q, clk_div_d;

  logic             xfer;
  logic             period_end;
  logic [WIDTH-1:0] div_eff;

  assign xfer       = i_div_vld & ~pend_vld_q;
  assign period_end = (state_q != StIdle) && (cnt_q == (act_div_q - One));
  // A ratio of zero behaves as divide-by-one.
  assign div_eff    = (i_div == '0) ? One : i_div;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!i_en) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (i_en) begin
          state_d = StRun;
        end else if (period_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy    = (state_q != StIdle);
    o_clk_en  = period_end;
    o_div_rdy = ~pend_vld_q;
    o_clk_div = clk_div_q;
  end

  // Counter, active ratio and staging register
  always_comb begin
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (state_q == StIdle) begin
      cnt_d = '0;
      if (pend_vld_q) begin
        act_div_d  = pend_q;
        pend_vld_d = 1'b0;
      end
      if (xfer) begin
        pend_d     = div_eff;
        pend_vld_d = 1'b1;
      end
    end else if (period_end) begin
      cnt_d = '0;
      // A ratio arriving on the boundary itself bypasses the staging register.
      if (xfer) begin
        act_div_d = div_eff;
      end else if (pend_vld_q) begin
        act_div_d  = pend_q;
        pend_vld_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + One;
      if (xfer) begin
        pend_d     = div_eff;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      act_div_q  <= One;
      pend_q     <= One;
      pend_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // Square wave is precomputed from next-state values so the flop lines up with cnt.
  assign clk_div_d = (state_d != StIdle) && (cnt_d < (act_div_d >> 1));

  if (TECHNOLOGY == 0) begin : g_clk_div_beh
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        clk_div_q <= 1'b0;
      end else begin
        clk_div_q <= clk_div_d;
      end
    end
  end else begin : g_clk_div_tech
    // No cell library is bound for other technologies yet; keep a plain flop.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        clk_div_q <= 1'b0;
      end else begin
        clk_div_q <= clk_div_d;
      end
    end
  end

endmodule

// File: tb/tb_ehl_clk_div_ctrl.sv
// Bench for ehl_clk_div_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a period-level reference model.
module tb_ehl_clk_div_ctrl;

  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         i_en      = 1'b0;
  logic [W-1:0] i_div     = '0;
  logic         i_div_vld = 1'b0;
  logic         o_div_rdy, o_clk_en, o_clk_div, o_busy;

  int n_chk  = 0;
  int n_fail = 0;

  ehl_clk_div_ctrl #(
    .WIDTH      (W),
    .TECHNOLOGY (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_en      (i_en),
    .i_div     (i_div),
    .i_div_vld (i_div_vld),
    .o_div_rdy (o_div_rdy),
    .o_clk_en  (o_clk_en),
    .o_clk_div (o_clk_div),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, position within the period, period length, staged ratio.
  typedef enum int {MIdle, MRun, MStop} mst_e;
  mst_e m_st   = MIdle;
  int   m_cnt  = 0;
  int   m_e    = 1;
  int   m_pend[$];

  initial begin : model
    bit xfer, at_end;
    int nv;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_st  = MIdle;
        m_cnt = 0;
        m_e   = 1;
        m_pend.delete();
      end else begin
        xfer   = (i_div_vld === 1'b1) && (m_pend.size() == 0);
        nv     = (i_div == 0) ? 1 : int'(i_div);
        at_end = (m_st != MIdle) && (m_cnt == m_e - 1);
        if (m_st == MIdle) begin
          if (m_pend.size() != 0) m_e = m_pend.pop_front();
          if (xfer) m_pend.push_back(nv);
          if (i_en) m_st = MRun;
        end else begin
          if (at_end) begin
            m_cnt = 0;
            if (xfer) m_e = nv;
            else if (m_pend.size() != 0) m_e = m_pend.pop_front();
          end else begin
            m_cnt++;
            if (xfer) m_pend.push_back(nv);
          end
          if (m_st == MRun) begin
            if (!i_en) m_st = MStop;
          end else if (i_en) begin
            m_st = MRun;
          end else if (at_end) begin
            m_st = MIdle;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("mdl_clk_en",  32'(o_clk_en),  32'(m_st != MIdle && m_cnt == m_e - 1));
      chk("mdl_clk_div", 32'(o_clk_div), 32'(m_st != MIdle && m_cnt < m_e / 2));
      chk("mdl_busy",    32'(o_busy),    32'(m_st != MIdle));
      chk("mdl_div_rdy", 32'(o_div_rdy), 32'(m_pend.size() == 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    i_div     = W'(n);
    i_div_vld = 1'b1;
    step();
    i_div_vld = 1'b0;
  endtask

  task automatic wait_pulse(input int bound);
    int k;
    k = 0;
    while (o_clk_en !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    chk("wait_pulse_timeout", 32'(o_clk_en), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_clk_en"},  32'(o_clk_en),  32'd0);
    chk({tag, "_clk_div"}, 32'(o_clk_div), 32'd0);
    chk({tag, "_busy"},    32'(o_busy),    32'd0);
    chk({tag, "_div_rdy"}, 32'(o_div_rdy), 32'd1);
  endtask

  initial begin : directed
    logic [31:0] en_p, dv_p, rd_p;
    int          cnt;

    // Reset values, observed before any clock edge.
    #1 reset = 1'b1;
    #1 check_reset_vals("rst_init");
    step();
    step();
    reset = 1'b0;
    step();

    // N=4: pulse every 4 cycles, square wave 1100.
    load(4);
    chk("n4_rdy_staged", 32'(o_div_rdy), 32'd0);
    step();
    chk("n4_rdy_loaded", 32'(o_div_rdy), 32'd1);
    i_en = 1'b1;
    step();
    chk("n4_busy", 32'(o_busy), 32'd1);
    en_p = '0; dv_p = '0;
    for (int k = 0; k < 8; k++) begin
      en_p[7-k] = o_clk_en;
      dv_p[7-k] = o_clk_div;
      step();
    end
    chk("n4_div_pat", dv_p, 32'b11001100);
    chk("n4_en_pat",  en_p, 32'b00010001);

    // N=5 running, N=3 staged mid-period; i_div wiggles while not ready.
    load(5);
    wait_pulse(20);
    step();
    en_p = '0; dv_p = '0; rd_p = '0;
    for (int k = 0; k < 5; k++) begin
      en_p[4-k] = o_clk_en;
      dv_p[4-k] = o_clk_div;
      rd_p[4-k] = o_div_rdy;
      i_div_vld = (k >= 2);
      i_div     = (k == 2) ? W'(3) : W'(9);
      step();
    end
    i_div_vld = 1'b0;
    chk("n5_div_pat", dv_p, 32'b11000);
    chk("n5_en_pat",  en_p, 32'b00001);
    chk("n5_rdy_pat", rd_p, 32'b11100);
    en_p = '0; dv_p = '0; rd_p = '0;
    for (int k = 0; k < 6; k++) begin
      en_p[5-k] = o_clk_en;
      dv_p[5-k] = o_clk_div;
      rd_p[5-k] = o_div_rdy;
      step();
    end
    chk("n3_div_pat", dv_p, 32'b100100);
    chk("n3_en_pat",  en_p, 32'b001001);
    chk("n3_rdy_pat", rd_p, 32'b111111);

    // Transfer on the boundary cycle: applied directly, ready never drops.
    wait_pulse(10);
    chk("fwd_rdy_before", 32'(o_div_rdy), 32'd1);
    load(2);
    chk("fwd_rdy_after", 32'(o_div_rdy), 32'd1);
    en_p = '0; dv_p = '0;
    for (int k = 0; k < 4; k++) begin
      en_p[3-k] = o_clk_en;
      dv_p[3-k] = o_clk_div;
      step();
    end
    chk("n2_div_pat", dv_p, 32'b1010);
    chk("n2_en_pat",  en_p, 32'b0101);

    // N=0 and N=1: enable every cycle, square wave flat low.
    load(0);
    wait_pulse(10);
    step();
    en_p = '0; dv_p = '0;
    for (int k = 0; k < 4; k++) begin
      en_p[3-k] = o_clk_en;
      dv_p[3-k] = o_clk_div;
      step();
    end
    chk("n0_en_pat",  en_p, 32'b1111);
    chk("n0_div_pat", dv_p, 32'b0000);
    load(1);
    en_p = '0; dv_p = '0; rd_p = '0;
    for (int k = 0; k < 4; k++) begin
      en_p[3-k] = o_clk_en;
      dv_p[3-k] = o_clk_div;
      rd_p[3-k] = o_div_rdy;
      step();
    end
    chk("n1_en_pat",  en_p, 32'b1111);
    chk("n1_div_pat", dv_p, 32'b0000);
    chk("n1_rdy_pat", rd_p, 32'b1111);

    // N=6, drop enable at cnt=2: period finishes in STOP, then idle.
    load(6);
    step();
    step();
    i_en = 1'b0;
    step();
    chk("stop_busy", 32'(o_busy), 32'd1);
    en_p = '0; dv_p = '0;
    for (int k = 0; k < 3; k++) begin
      en_p[2-k] = o_clk_en;
      dv_p[2-k] = o_clk_div;
      step();
    end
    chk("stop_en_pat",  en_p, 32'b001);
    chk("stop_div_pat", dv_p, 32'b000);
    chk("stop_idle_busy", 32'(o_busy),    32'd0);
    chk("stop_idle_div",  32'(o_clk_div), 32'd0);
    chk("stop_idle_en",   32'(o_clk_en),  32'd0);

    // Largest ratio gives a 255-cycle period.
    load(255);
    step();
    i_en = 1'b1;
    step();
    cnt = 1;
    while (o_clk_en !== 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    chk("n255_period", 32'(cnt), 32'd255);
    i_en = 1'b0;
    cnt = 0;
    while (o_busy !== 1'b0 && cnt < 400) begin
      step();
      cnt++;
    end
    chk("n255_idle", 32'(o_busy), 32'd0);

    // Reset mid-period with a staged ratio: immediate, and staged ratio is lost.
    load(4);
    step();
    i_en = 1'b1;
    step();
    step();
    load(7);
    chk("rst_rdy_staged", 32'(o_div_rdy), 32'd0);
    step();
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_async");
    step();
    step();
    reset = 1'b0;
    step();
    en_p = '0; dv_p = '0;
    for (int k = 0; k < 4; k++) begin
      en_p[3-k] = o_clk_en;
      dv_p[3-k] = o_clk_div;
      step();
    end
    chk("rst_act1_en_pat",  en_p, 32'b1111);
    chk("rst_act1_div_pat", dv_p, 32'b0000);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      if (reset) begin
        if ($urandom_range(0, 3) == 0) reset = 1'b0;
      end else if ($urandom_range(0, 999) < 3) begin
        reset = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) i_en = ~i_en;
      i_div_vld = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       i_div = '0;
        1:       i_div = W'(1);
        2:       i_div = '1;
        default: i_div = W'($urandom_range(2, 12));
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
